uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 144 ++++++++++++++
 tb/tb_uart_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver. 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Latency: Rx_VALID one clk after the stop-bit centre sample (9.5 / 10.5 bit periods + 3 clks from start edge).
// Backpressure: none; Rx_VALID is a one-cycle pulse and Rx_DATA/flags hold until the next completed frame.
module uart_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_sync, rx_prev;
    logic [2:0]  baud_lat;
    logic [13:0] div_cnt;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_dat;
    logic        tick, centre, start_det;
    logic        shift_en, frame_done;

    function automatic logic [13:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'b000:  return 14'd10417;
            3'b001:  return 14'd2604;
            3'b010:  return 14'd651;
            3'b011:  return 14'd326;
            3'b100:  return 14'd163;
            3'b101:  return 14'd81;
            3'b110:  return 14'd54;
            default: return 14'd27;
        endcase
    endfunction

    assign start_det = (state == IDLE) && Rx_EN && rx_prev && !rx_sync;
    assign tick      = (div_cnt == baud_div(baud_lat) - 14'd1);
    // Start bit is judged 8 ticks in; every later bit 16 ticks after the previous centre.
    assign centre    = tick && ((state == START) ? (tick_cnt == 4'd7) : (tick_cnt == 4'd15));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!Rx_EN) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:   if (start_det) state_nxt = START;
                START:  if (centre) state_nxt = rx_sync ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                DATA:   if (centre && bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY: if (centre) state_nxt = STOP;
`else
                DATA:   if (centre && bit_cnt == 3'd7) state_nxt = STOP;
`endif
                STOP:   if (centre) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en   = (state == DATA) && centre;
        frame_done = (state == STOP) && centre && Rx_EN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            baud_lat  <= 3'd0;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_dat <= '0;
        end else begin
            rx_meta <= RxD;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (start_det) baud_lat <= baud_select;
            // Divider and sample counter sit at zero in IDLE, so they restart at the start edge.
            if (state == IDLE || !Rx_EN) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                div_cnt <= tick ? 14'd0 : div_cnt + 14'd1;
                if (state == START && centre) tick_cnt <= 4'd0;
                else if (tick)                tick_cnt <= tick_cnt + 4'd1;
                if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) shift_dat <= {rx_sync, shift_dat[7:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID <= frame_done;
            if (frame_done) begin
                Rx_DATA   <= shift_dat;
                Rx_FERROR <= !rx_sync;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit   <= 1'b0;
            Rx_PERROR <= 1'b0;
        end else begin
            if (state == PARITY && centre) par_bit <= rx_sync;
            if (frame_done) Rx_PERROR <= (^shift_dat) ^ par_bit;
        end
    end
`else
    assign Rx_PERROR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed REQ frames plus random frames, checked against a frame-level model.
module tb_uart_receiver;

    localparam int HALF   = 10;
    localparam int PERIOD = 2 * HALF;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // Start edge to stop-bit centre, in oversample ticks (10.5 or 9.5 bit periods).
    localparam int LAT_TICKS = PAR ? 168 : 152;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;

    uart_receiver dut (
        .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
        .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR)
    );

    initial forever #HALF clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       p;
        longint     t0;
        int         dv;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_f = 1'b0;
    logic       hold_p = 1'b0;
    logic       prev_vld = 1'b0;

    function automatic int div_of(input logic [2:0] sel);
        case (sel)
            3'b000:  return 10417;
            3'b001:  return 2604;
            3'b010:  return 651;
            3'b011:  return 326;
            3'b100:  return 163;
            3'b101:  return 81;
            3'b110:  return 54;
            default: return 27;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Per-cycle compare against the frame model.
    always @(negedge clk) begin
        exp_t   e;
        longint lat;
        longint lo;
        longint hi;
        if (!reset) begin
            chk("rst_valid", Rx_VALID, 0);
            chk("rst_data", Rx_DATA, 0);
            chk("rst_ferror", Rx_FERROR, 0);
            chk("rst_perror", Rx_PERROR, 0);
        end else if (Rx_VALID) begin
            chk("vld_one_cycle", prev_vld, 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_vld: got Rx_VALID=1 required 0 (no frame pending)");
            end else begin
                e = exp_q.pop_front();
                chk("frame_data", Rx_DATA, e.d);
                chk("frame_ferror", Rx_FERROR, e.f);
                chk("frame_perror", Rx_PERROR, e.p);
                lat = ($time - e.t0) / PERIOD;
                lo  = longint'(LAT_TICKS) * e.dv + 1;
                hi  = longint'(LAT_TICKS) * e.dv + 5;
                n_cmp++;
                if (lat < lo || lat > hi) begin
                    n_err++;
                    $display("FAIL frame_latency: got %0d clks required %0d..%0d", lat, lo, hi);
                end
                hold_d = e.d;
                hold_f = e.f;
                hold_p = e.p;
            end
        end else begin
            chk("hold_data", Rx_DATA, hold_d);
            chk("hold_ferror", Rx_FERROR, hold_f);
            chk("hold_perror", Rx_PERROR, hold_p);
        end
        prev_vld = Rx_VALID;
    end

    // abort_mode: 0 none, 1 drop Rx_EN after data bit 3, 2 assert reset after data bit 3.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input logic [2:0] sel, input int abort_mode, input bit expect_vld);
        exp_t e;
        int   bt;
        bt = 16 * div_of(sel) * PERIOD;
        @(posedge clk);
        #3;
        baud_select = sel;
        RxD = 1'b0;
        if (expect_vld) begin
            e.d  = d;
            e.f  = !stp;
            e.p  = PAR ? ((^d) ^ par) : 1'b0;
            e.t0 = $time;
            e.dv = div_of(sel);
            exp_q.push_back(e);
        end
        #(bt);
        // The receiver latched its rate at the start edge; scramble the select for the rest of the frame.
        baud_select = 3'($urandom);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            #(bt);
            if (i == 3 && abort_mode == 1) begin
                Rx_EN = 1'b0;
                RxD = 1'b1;
                #(bt);
                chk("en_abort_hold_data", Rx_DATA, hold_d);
                Rx_EN = 1'b1;
                baud_select = sel;
                return;
            end
            if (i == 3 && abort_mode == 2) begin
                hold_d = 8'h00;
                hold_f = 1'b0;
                hold_p = 1'b0;
                reset = 1'b0;
                RxD = 1'b1;
                repeat (4) @(negedge clk);
                chk("rst_abort_data", Rx_DATA, 8'h00);
                chk("rst_abort_valid", Rx_VALID, 0);
                chk("rst_abort_ferror", Rx_FERROR, 0);
                chk("rst_abort_perror", Rx_PERROR, 0);
                reset = 1'b1;
                baud_select = sel;
                return;
            end
        end
        if (PAR) begin
            RxD = par;
            #(bt);
        end
        RxD = stp;
        #(bt);
        baud_select = sel;
    endtask

    task automatic idle_ticks(input int n, input logic [2:0] sel);
        RxD = 1'b1;
        #(n * div_of(sel) * PERIOD);
    endtask

    task automatic drain;
        for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;
        reset = 1'b0;
        Rx_EN = 1'b1;
        RxD = 1'b1;
        baud_select = 3'b111;
        repeat (3) @(negedge clk);
        chk("init_data", Rx_DATA, 8'h00);
        chk("init_valid", Rx_VALID, 0);
        chk("init_ferror", Rx_FERROR, 0);
        chk("init_perror", Rx_PERROR, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(8'hA5, 1'b0, 1'b1, 3'b111, 0, 1);
        idle_ticks(4, 3'b111);
        drain();
        chk("a5_data", Rx_DATA, 8'hA5);
        chk("a5_ferror", Rx_FERROR, 0);
        chk("a5_perror", Rx_PERROR, 0);

        send_frame(8'h3C, 1'b1, 1'b1, 3'b110, 0, 1);
        idle_ticks(4, 3'b110);
        drain();
        chk("3c_data", Rx_DATA, 8'h3C);
        chk("3c_ferror", Rx_FERROR, 0);
        chk("3c_perror", Rx_PERROR, PAR ? 1 : 0);

        send_frame(8'h55, 1'b0, 1'b0, 3'b111, 0, 1);
        idle_ticks(16, 3'b111);
        drain();
        chk("55_data", Rx_DATA, 8'h55);
        chk("55_ferror", Rx_FERROR, 1);
        send_frame(8'h0F, 1'b0, 1'b1, 3'b111, 0, 1);
        idle_ticks(4, 3'b111);
        drain();
        chk("0f_data", Rx_DATA, 8'h0F);
        chk("0f_ferror", Rx_FERROR, 0);

        // Four-tick low glitch must be rejected at the start-bit centre.
        @(posedge clk);
        RxD = 1'b0;
        #(4 * div_of(3'b111) * PERIOD);
        idle_ticks(32, 3'b111);
        send_frame(8'h81, 1'b0, 1'b1, 3'b111, 0, 1);
        idle_ticks(4, 3'b111);
        drain();
        chk("81_data", Rx_DATA, 8'h81);

        send_frame(8'hFF, 1'b0, 1'b1, 3'b111, 1, 0);
        idle_ticks(32, 3'b111);
        chk("en_abort_data", Rx_DATA, 8'h81);
        send_frame(8'h12, 1'b0, 1'b1, 3'b111, 0, 1);
        idle_ticks(4, 3'b111);
        drain();
        chk("12a_data", Rx_DATA, 8'h12);

        send_frame(8'hFF, 1'b0, 1'b1, 3'b111, 2, 0);
        idle_ticks(32, 3'b111);
        send_frame(8'h12, 1'b0, 1'b1, 3'b111, 0, 1);
        idle_ticks(4, 3'b111);
        drain();
        chk("12b_data", Rx_DATA, 8'h12);

        send_frame(8'hA5, 1'b0, 1'b1, 3'b111, 0, 1);
        send_frame(8'h5A, 1'b0, 1'b1, 3'b111, 0, 1);
        idle_ticks(4, 3'b111);
        drain();
        chk("b2b_data", Rx_DATA, 8'h5A);
        chk("b2b_perror", Rx_PERROR, 0);

        // Break: line held low well past the stop bit.
        send_frame(8'h00, 1'b0, 1'b0, 3'b111, 0, 1);
        #(32 * div_of(3'b111) * PERIOD);
        idle_ticks(16, 3'b111);
        drain();
        chk("break_data", Rx_DATA, 8'h00);
        chk("break_ferror", Rx_FERROR, 1);

        for (int k = 0; k < 2; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rp, rs, 3'b111, 0, 1);
            idle_ticks($urandom_range(1, 6), 3'b111);
        end
        idle_ticks(4, 3'b111);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
